fetch_prefetch_queue: RTL and testbench

//  Fetch stage with a small prefetch FIFO; sits between instruction memory and the IF/ID path,

---
 rtl/fetch_prefetch_queue.sv | 186 ++++++++++++++++++
 tb/tb_fetch_prefetch_queue.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: instruction fetch stage with a small prefetch FIFO.
// Issues word reads to a 1-cycle-latency instruction memory, queues the returned
// {inst, pc+4} pairs and hands them to decode under a valid/ready handshake.
// A redirect (pc_src) flushes the queue and any in-flight read.
// Optional build macro: FETCH_STATS_EN adds stat_fetched / stat_flushed counters.
module fetch_prefetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pc_src,
   input  logic [31:0] add_res,
   output logic        imem_en,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic        d_valid,
   input  logic        d_ready,
   output logic [31:0] d_inst,
   output logic [31:0] d_pc
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0] stat_fetched,
   output logic [31:0] stat_flushed
`endif
);

   localparam int            PW       = $clog2(DEPTH);
   localparam int            CW       = PW + 1;
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);
   localparam logic [PW-1:0] PTR_ZERO = PW'(0);

   logic [31:0]   f_pc_q,     f_pc_d;
   logic [31:0]   req_pc_q,   req_pc_d;
   logic          inflight_q, inflight_d;
   logic [CW-1:0] count_q,    count_d;
   logic [PW-1:0] rd_ptr_q,   rd_ptr_d;
   logic [PW-1:0] wr_ptr_q,   wr_ptr_d;
   logic [31:0]   inst_q [DEPTH];
   logic [31:0]   inst_d [DEPTH];
   logic [31:0]   npc_q  [DEPTH];
   logic [31:0]   npc_d  [DEPTH];

   logic [CW-1:0] occ_s;
   logic          issue_s;
   logic          valid_s;
   logic          push_s;
   logic          pop_s;
   logic [31:0]   target_s;

`ifdef FETCH_STATS_EN
   logic [31:0]   stat_fetched_q, stat_fetched_d;
   logic [31:0]   stat_flushed_q, stat_flushed_d;
`endif

   // Handshake decode: credit-based issue, head-valid and the redirect target.
   always_comb begin
      occ_s    = count_q + {{(CW-1){1'b0}}, inflight_q};
      issue_s  = rst && !pc_src && (occ_s < DEPTH_C);
      valid_s  = rst && !pc_src && (count_q != CNT_ZERO);
      // A response is only pushed when no redirect discards it.
      push_s   = inflight_q && !pc_src;
      pop_s    = valid_s && d_ready;
      // Low two target bits are forced to zero (word-aligned fetch).
      target_s = add_res & 32'hFFFF_FFFC;
   end

   // Next-state for fetch PC, in-flight tracking and the FIFO.
   always_comb begin
      f_pc_d     = f_pc_q;
      req_pc_d   = req_pc_q;
      inflight_d = inflight_q;
      count_d    = count_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      inst_d     = inst_q;
      npc_d      = npc_q;
      if (pc_src) begin
         f_pc_d     = target_s;
         inflight_d = 1'b0;
         count_d    = CNT_ZERO;
         rd_ptr_d   = PTR_ZERO;
         wr_ptr_d   = PTR_ZERO;
      end else begin
         if (issue_s) begin
            f_pc_d     = f_pc_q + 32'd4;
            req_pc_d   = f_pc_q;
            inflight_d = 1'b1;
         end else begin
            inflight_d = 1'b0;
         end
         if (push_s) begin
            inst_d[wr_ptr_q] = imem_rdata;
            npc_d[wr_ptr_q]  = req_pc_q + 32'd4;
            wr_ptr_d         = wr_ptr_q + PTR_ONE;
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

`ifdef FETCH_STATS_EN
   // Statistics: accepted pops, and words discarded by each flush edge.
   always_comb begin
      stat_fetched_d = stat_fetched_q;
      stat_flushed_d = stat_flushed_q;
      if (pop_s) begin
         stat_fetched_d = stat_fetched_q + 32'd1;
      end else begin
         stat_fetched_d = stat_fetched_q;
      end
      if (pc_src) begin
         stat_flushed_d = stat_flushed_q + {{(32-CW){1'b0}}, occ_s};
      end else begin
         stat_flushed_d = stat_flushed_q;
      end
   end

   // Statistics counter registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stat_fetched_q <= 32'h0000_0000;
         stat_flushed_q <= 32'h0000_0000;
      end else begin
         stat_fetched_q <= stat_fetched_d;
         stat_flushed_q <= stat_flushed_d;
      end
   end

   assign stat_fetched = stat_fetched_q;
   assign stat_flushed = stat_flushed_q;
`endif

   // State registers; reset drops the queue and any in-flight read.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         f_pc_q     <= RESET_PC;
         req_pc_q   <= 32'h0000_0000;
         inflight_q <= 1'b0;
         count_q    <= CNT_ZERO;
         rd_ptr_q   <= PTR_ZERO;
         wr_ptr_q   <= PTR_ZERO;
         for (int i = 0; i < DEPTH; i++) begin
            inst_q[i] <= 32'h0000_0000;
            npc_q[i]  <= 32'h0000_0000;
         end
      end else begin
         f_pc_q     <= f_pc_d;
         req_pc_q   <= req_pc_d;
         inflight_q <= inflight_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         inst_q     <= inst_d;
         npc_q      <= npc_d;
      end
   end

   // Output drive: head entry only while valid, nop otherwise.
   always_comb begin
      imem_en   = issue_s;
      imem_addr = f_pc_q;
      d_valid   = valid_s;
      if (valid_s) begin
         d_inst = inst_q[rd_ptr_q];
         d_pc   = npc_q[rd_ptr_q];
      end else begin
         d_inst = 32'h0000_0000;
         d_pc   = 32'h0000_0000;
      end
   end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: directed scenarios plus randomized decode
// back-pressure and redirects, compared cycle by cycle against a queue-based
// reference model of the fetch stage.
module tb_fetch_prefetch_queue;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        pc_src = 1'b0;
   logic [31:0] add_res = 32'h0;
   logic        imem_en;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = 32'h0;
   logic        d_valid;
   logic        d_ready = 1'b0;
   logic [31:0] d_inst;
   logic [31:0] d_pc;
`ifdef FETCH_STATS_EN
   logic [31:0] stat_fetched;
   logic [31:0] stat_flushed;
`endif

   fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst(rst), .pc_src(pc_src), .add_res(add_res),
      .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .d_valid(d_valid), .d_ready(d_ready), .d_inst(d_inst), .d_pc(d_pc)
`ifdef FETCH_STATS_EN
      , .stat_fetched(stat_fetched), .stat_flushed(stat_flushed)
`endif
   );

   always #5 clk = ~clk;

   int pass_cnt = 0;
   int total    = 0;

   // memory environment: request captured this cycle, answered next cycle
   logic        rsp_due  = 1'b0;
   logic [31:0] rsp_addr = 32'h0;

   // reference model state
   logic [31:0] m_fpc = RESET_PC;
   logic        m_pend = 1'b0;
   logic [31:0] m_pend_pc = 32'h0;
   logic [63:0] m_q[$];
   logic [31:0] m_fetched = 32'h0;
   logic [31:0] m_flushed = 32'h0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {2'b00, a[31:2]} + 32'h0000_0100;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_fpc = RESET_PC; m_pend = 1'b0; m_q.delete();
      m_fetched = 32'h0; m_flushed = 32'h0;
      rsp_due = 1'b0;
   endtask

   // one cycle: entered just after a falling edge, leaves after the next one
   task automatic step(input logic src, input logic [31:0] tgt, input logic rdy);
      logic        e_en, e_dv;
      logic [31:0] e_inst, e_pc;
      int          occ;
      imem_rdata = rsp_due ? mem_word(rsp_addr) : 32'hDEAD_BEEF;
      pc_src = src; add_res = tgt; d_ready = rdy;
      #1;
      occ    = m_q.size() + (m_pend ? 1 : 0);
      e_en   = !src && (occ < DEPTH);
      e_dv   = !src && (m_q.size() != 0);
      e_inst = 32'h0; e_pc = 32'h0;
      if (e_dv) begin
         e_inst = m_q[0][63:32];
         e_pc   = m_q[0][31:0];
      end
      chk("imem_en", {31'h0, imem_en}, {31'h0, e_en});
      chk("imem_addr", imem_addr, m_fpc);
      chk("d_valid", {31'h0, d_valid}, {31'h0, e_dv});
      chk("d_inst", d_inst, e_inst);
      chk("d_pc", d_pc, e_pc);
`ifdef FETCH_STATS_EN
      chk("stat_fetched", stat_fetched, m_fetched);
      chk("stat_flushed", stat_flushed, m_flushed);
`endif
      rsp_due = imem_en; rsp_addr = imem_addr;
      if (src) begin
         m_flushed = m_flushed + 32'(occ);
         m_q.delete(); m_pend = 1'b0;
         m_fpc = tgt & 32'hFFFF_FFFC;
      end else begin
         if (e_dv && rdy) begin
            void'(m_q.pop_front());
            m_fetched = m_fetched + 32'd1;
         end
         if (m_pend) m_q.push_back({mem_word(m_pend_pc), m_pend_pc + 32'd4});
         if (e_en) begin
            m_pend = 1'b1; m_pend_pc = m_fpc; m_fpc = m_fpc + 32'd4;
         end else begin
            m_pend = 1'b0;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] flushed_before;
      // reset state
      #1;
      chk("rst_imem_en", {31'h0, imem_en}, 32'h0);
      chk("rst_imem_addr", imem_addr, RESET_PC);
      chk("rst_d_valid", {31'h0, d_valid}, 32'h0);
      chk("rst_d_inst", d_inst, 32'h0);
      chk("rst_d_pc", d_pc, 32'h0);
      @(negedge clk);
      rst = 1'b1;

      // 1: streaming with decode always ready; first word visible at cycle 2
      step(1'b0, 32'h0, 1'b1);
      step(1'b0, 32'h0, 1'b1);
      chk("t1_first_valid", {31'h0, d_valid}, 32'h1);
      chk("t1_first_inst", d_inst, 32'h0000_0100);
      chk("t1_first_pc", d_pc, 32'h0000_0004);
      for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1);

      // 2: decode stalled long enough to fill, then drain
      for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1);

      // 3: flush with 3 queued + 1 in flight, target 0x43 aligns to 0x40
      step(1'b1, 32'h0000_0200, 1'b0);
      for (int i = 0; i < 20 && m_q.size() != 3; i++) step(1'b0, 32'h0, 1'b0);
      flushed_before = m_flushed;
      step(1'b1, 32'h0000_0043, 1'b1);
      chk("t3_flush_count", m_flushed - flushed_before, 32'd4);
      chk("t3_target_addr", imem_addr, 32'h0000_0040);
      for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1);

      // 4: redirect on the cycle right after an issue
      step(1'b0, 32'h0, 1'b1);
      step(1'b1, 32'h0000_0800, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1);

      // 5: fill, then sustained pop+push
      for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1);

      // held redirect: last target wins
      step(1'b1, 32'h0000_1000, 1'b1);
      step(1'b1, 32'h0000_2000, 1'b1);
      step(1'b1, 32'h0000_3002, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);

      // address wrap at the top of the 32-bit space
      step(1'b1, 32'hFFFF_FFF8, 1'b1);
      for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1);

      // randomized back-pressure and redirects
      for (int i = 0; i < 300; i++)
         step(($urandom_range(0, 19) == 0), $urandom, ($urandom_range(0, 9) < 7));

      // 6: asynchronous reset away from any clock edge
      #3;
      rst = 1'b0;
      #1;
      chk("t6_imem_en", {31'h0, imem_en}, 32'h0);
      chk("t6_imem_addr", imem_addr, RESET_PC);
      chk("t6_d_valid", {31'h0, d_valid}, 32'h0);
      chk("t6_d_inst", d_inst, 32'h0);
      chk("t6_d_pc", d_pc, 32'h0);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
